// File: rtl/ifetch_prefetch_buffer.sv
// Instruction fetch prefetch buffer.
// Issues sequential word fetches under a credit limit, queues the returned
// instructions with their PCs in a DEPTH-entry FIFO, and flushes on core redirect.
// Optional build macro: IFETCH_PERF_COUNTERS_EN adds bubble/redirect counters.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr_data,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                perf_bubble_cnt,
    output logic [31:0]                perf_redirect_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic          credit_ok_c;
    logic          req_fire_c;
    logic          push_c;
    logic          drop_c;
    logic          pop_c;
    logic          head_ok_c;
    logic [31:0]   redirect_aligned_c;
    logic [CW-1:0] outstanding_nxt_c;

    // Handshake decode and credit check
    always_comb begin
        credit_ok_c        = (SW'(count) + SW'(outstanding)) < SW'(DEPTH);
        req_fire_c         = credit_ok_c && !redirect_valid && imem_req_ready;
        push_c             = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
        drop_c             = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);
        head_ok_c          = (count != '0);
        pop_c              = head_ok_c && !redirect_valid && instr_ready;
        redirect_aligned_c = redirect_pc & 32'hFFFF_FFFC;
        outstanding_nxt_c  = outstanding + CW'(req_fire_c) - CW'(imem_rsp_valid);
    end

    // Output view: request channel and FIFO head (forced to zero while in reset / empty)
    always_comb begin
        imem_req_valid = reset && credit_ok_c && !redirect_valid;
        imem_req_addr  = fetch_pc;
        instr_valid    = head_ok_c && !redirect_valid;
        instr_data     = head_ok_c ? mem_data[rd_ptr] : 32'd0;
        instr_pc       = head_ok_c ? mem_pc[rd_ptr]   : 32'd0;
        fifo_count     = count;
    end

    // Control state: PCs, pointers, occupancy, credits and stale-response drop count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt_c;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned_c;
                rsp_pc   <= redirect_aligned_c;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire_c) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop_c) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // FIFO storage: no reset needed, occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef IFETCH_PERF_COUNTERS_EN
    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubble_cnt   <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (instr_ready && !instr_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if (redirect_valid && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
